// File: rtl/sort_pkg.sv
// Shared definitions for the 8-byte selection sorter and its stream controller.
// Contents:
//   DW, AW, DEPTH - byte width, sorter address width and bytes per batch
//   TIMEOUT       - default sort watchdog limit, in SORT-state cycles
//   state_t       - stream controller FSM states
package sort_pkg;

    localparam int DW      = 8;
    localparam int AW      = 3;
    localparam int DEPTH   = 1 << AW;
    localparam int TIMEOUT = 255;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        KICK   = 3'd1,
        SETTLE = 3'd2,
        SORT   = 3'd3,
        RADDR  = 3'd4,
        RDATA  = 3'd5
    } state_t;

endpackage

// File: rtl/sort_stream_ctrl.sv
// Stream front/back end for the 8-byte selection sorter.
// The block collects DEPTH bytes from a valid/ready source and writes them into
// the sorter RAM. It then pulses start and waits for the sorter to finish. Last,
// it reads the sorted bytes back and sends them out in ascending order, one byte
// every two cycles.
// Ports:
//   clk, nrst              clock and synchronous active-low reset
//   in_valid/in_ready      input byte handshake, in_data carries the byte
//   out_valid/out_ready    output byte handshake, out_data carries the sorted byte,
//                          and out_last marks the final byte of the batch
//   busy                   high whenever the controller is not in LOAD
//   err                    sticky sort-timeout flag, cleared only by reset
//   s_start, s_wr, s_addr, s_datain   drives to the sorter user port
//   s_ready, s_dataout                sorter status and synchronous read data
module sort_stream_ctrl #(
    parameter int DW      = sort_pkg::DW,
    parameter int AW      = sort_pkg::AW,
    parameter int TIMEOUT = sort_pkg::TIMEOUT
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          err,
    output logic          s_start,
    output logic          s_wr,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_datain,
    input  logic          s_ready,
    input  logic [DW-1:0] s_dataout
);

    import sort_pkg::*;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    // The last SORT cycle that may still wait for the sorter. This gives
    // TIMEOUT SORT cycles in total before err is raised.
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] LAST_IDX = '1;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic            err_nxt;
    logic            out_valid_nxt;
    logic            out_last_nxt;
    logic [DW-1:0]   out_data_nxt;

    // Next-state logic and sorter-side drives
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tmr_nxt       = tmr;
        err_nxt       = err;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        out_data_nxt  = out_data;
        in_ready      = 1'b0;
        s_wr          = 1'b0;
        s_start       = 1'b0;

        case (state)
            LOAD: begin
                // Gating with nrst keeps the source from handing over a byte
                // that the reset would discard anyway.
                in_ready = s_ready & nrst;
                if (in_valid && in_ready) begin
                    s_wr    = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_nxt = KICK;
                    end
                end
            end
            KICK: begin
                s_start   = 1'b1;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                // The sorter has not dropped ready yet, so it is not sampled here.
                state_nxt = SORT;
            end
            SORT: begin
                if (s_ready) begin
                    tmr_nxt   = '0;
                    state_nxt = RADDR;
                end else if (tmr == TMR_LAST) begin
                    // Give up on this batch. The sorter is left to finish, and
                    // LOAD stays closed until it reports ready again.
                    err_nxt   = 1'b1;
                    tmr_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = LOAD;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            RADDR: begin
                out_data_nxt  = s_dataout;
                out_valid_nxt = 1'b1;
                out_last_nxt  = (cnt == LAST_IDX);
                state_nxt     = RDATA;
            end
            RDATA: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    cnt_nxt       = cnt + 1'b1;
                    state_nxt     = (cnt == LAST_IDX) ? LOAD : RADDR;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase

        // The sorter RAM returns data one cycle after the address. On the
        // accepting RDATA cycle, the next index is already presented. Its byte
        // is therefore on s_dataout during RADDR and is captured on entry to
        // RDATA. While stalled, the address stays at cnt.
        s_addr   = (state == RDATA) ? cnt_nxt : cnt;
        s_datain = in_data;
        busy     = (state != LOAD);
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= LOAD;
            cnt       <= '0;
            tmr       <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tmr       <= tmr_nxt;
            err       <= err_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            out_data  <= out_data_nxt;
        end
    end

endmodule
